// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the write-back sources and the register-file write port.
// Requests are packed per requester; the rf_* signals form the single write port.
interface regfile_wb_arbiter_if #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_adr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               rf_en;
   logic [AW-1:0]      rf_w_adr;
   logic [DW-1:0]      rf_w_data;

   modport master (
      output req_valid, req_adr, req_data,
      input  req_ready, rf_en, rf_w_adr, rf_w_data
   );

   modport slave (
      input  req_valid, req_adr, req_data,
      output req_ready, rf_en, rf_w_adr, rf_w_data
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port; one accepted write per
// cycle, registered once before reaching the register file. Writes to x0 are consumed and dropped.
module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  hold,
   output logic                  contend,
   regfile_wb_arbiter_if.slave   bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(NREQ + 1);

   logic [PW-1:0] ptr_q, ptr_d;
   logic          rf_en_q, rf_en_d;
   logic [AW-1:0] rf_w_adr_q, rf_w_adr_d;
   logic [DW-1:0] rf_w_data_q, rf_w_data_d;

   logic [PW-1:0]   gidx_s;
   logic            found_s;
   logic            grant_s;
   logic [CW-1:0]   vcnt_s;
   logic [NREQ-1:0] ready_s;
   logic [AW-1:0]   sel_adr_s;
   logic [DW-1:0]   sel_data_s;

   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      return PW'(sum % NREQ);
   endfunction

   // First valid requester at or after ptr, plus a count of valid requesters.
   always_comb begin
      found_s = 1'b0;
      gidx_s  = '0;
      vcnt_s  = '0;
      for (int k = 0; k < NREQ; k++) begin
         vcnt_s = vcnt_s + CW'(bus.req_valid[k]);
         if (!found_s && bus.req_valid[wrap_idx(ptr_q, k)]) begin
            found_s = 1'b1;
            gidx_s  = wrap_idx(ptr_q, k);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Grant is suppressed by hold and while reset is asserted.
   always_comb begin
      grant_s    = found_s && !hold && rst_n;
      ready_s    = '0;
      sel_adr_s  = bus.req_adr[int'(gidx_s)*AW +: AW];
      sel_data_s = bus.req_data[int'(gidx_s)*DW +: DW];
      if (grant_s) begin
         ready_s[gidx_s] = 1'b1;
      end else begin
         ready_s = '0;
      end
   end

   // Next pointer and write-port registers; an x0 grant advances ptr but writes nothing.
   always_comb begin
      ptr_d       = ptr_q;
      rf_en_d     = 1'b0;
      rf_w_adr_d  = rf_w_adr_q;
      rf_w_data_d = rf_w_data_q;
      if (grant_s) begin
         ptr_d = (gidx_s == PW'(NREQ - 1)) ? '0 : gidx_s + PW'(1);
         if (sel_adr_s != '0) begin
            rf_en_d     = 1'b1;
            rf_w_adr_d  = sel_adr_s;
            rf_w_data_d = sel_data_s;
         end else begin
            rf_en_d = 1'b0;
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         rf_en_q     <= 1'b0;
         rf_w_adr_q  <= '0;
         rf_w_data_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         rf_en_q     <= rf_en_d;
         rf_w_adr_q  <= rf_w_adr_d;
         rf_w_data_q <= rf_w_data_d;
      end
   end

   assign bus.req_ready = ready_s;
   assign bus.rf_en     = rf_en_q;
   assign bus.rf_w_adr  = rf_w_adr_q;
   assign bus.rf_w_data = rf_w_data_q;
   assign contend       = rst_n && !hold && (vcnt_s >= CW'(2));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed test of regfile_wb_arbiter: reset, latency, round-robin order, x0 drop,
// hold, write ordering and reset in mid-stream.
module tb_regfile_wb_arbiter;
   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic clk = 1'b0;
   logic rst_n;
   logic hold;
   logic contend;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [DW-1:0] rf_model [0:31];

   regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus_if ();

   regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold    (hold),
      .contend (contend),
      .bus     (bus_if)
   );

   always #5 clk = ~clk;

   // Register-file model fed by the write port.
   always @(posedge clk) begin
      if (bus_if.rf_en) rf_model[bus_if.rf_w_adr] <= bus_if.rf_w_data;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_rf(input string tag, input logic en, input logic [AW-1:0] adr,
                           input logic [DW-1:0] data);
      check_eq({tag, ".rf_en"}, 64'(bus_if.rf_en), 64'(en));
      check_eq({tag, ".rf_w_adr"}, 64'(bus_if.rf_w_adr), 64'(adr));
      check_eq({tag, ".rf_w_data"}, 64'(bus_if.rf_w_data), 64'(data));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus_if.req_adr[i*AW +: AW]  = a;
      bus_if.req_data[i*DW +: DW] = d;
   endtask

   logic [2:0]  rr_ready [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [4:0]  rr_adr   [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
   logic [31:0] rr_data  [6] = '{32'hA0, 32'hB1, 32'hC2, 32'hA0, 32'hB1, 32'hC2};

   initial begin
      rst_n            = 1'b0;
      hold             = 1'b0;
      bus_if.req_valid = 3'b111;
      bus_if.req_adr   = '0;
      bus_if.req_data  = '0;
      set_req(0, 5'd1, 32'hA0);
      set_req(1, 5'd2, 32'hB1);
      set_req(2, 5'd3, 32'hC2);
      #2;
      check_eq("rst.ready", 64'(bus_if.req_ready), 64'd0);
      check_eq("rst.contend", 64'(contend), 64'd0);
      check_rf("rst", 1'b0, 5'd0, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("release.ready", 64'(bus_if.req_ready), 64'b001);

      for (int i = 0; i < 6; i++) begin
         check_eq("rr.ready", 64'(bus_if.req_ready), 64'(rr_ready[i]));
         check_eq("rr.contend", 64'(contend), 64'd1);
         step();
         check_rf("rr", 1'b1, rr_adr[i], rr_data[i]);
      end

      bus_if.req_valid = 3'b010;
      set_req(1, 5'd5, 32'hDEADBEEF);
      #1;
      check_eq("single.ready", 64'(bus_if.req_ready), 64'b010);
      check_eq("single.contend", 64'(contend), 64'd0);
      step();
      check_rf("single.n1", 1'b1, 5'd5, 32'hDEADBEEF);
      bus_if.req_valid = 3'b000;
      #1;
      check_eq("idle.ready", 64'(bus_if.req_ready), 64'd0);
      step();
      check_rf("single.n2", 1'b0, 5'd5, 32'hDEADBEEF);

      bus_if.req_valid = 3'b001;
      set_req(0, 5'd9, 32'h99);
      #1;
      check_eq("p2.ready", 64'(bus_if.req_ready), 64'b001);
      step();
      check_rf("p2", 1'b1, 5'd9, 32'h99);
      bus_if.req_valid = 3'b101;
      #1;
      check_eq("sparse.ready0", 64'(bus_if.req_ready), 64'b100);
      check_eq("sparse.contend", 64'(contend), 64'd1);
      step();
      check_rf("sparse.w0", 1'b1, 5'd3, 32'hC2);
      check_eq("sparse.ready1", 64'(bus_if.req_ready), 64'b001);
      step();
      check_rf("sparse.w1", 1'b1, 5'd9, 32'h99);

      bus_if.req_valid = 3'b001;
      set_req(0, 5'd0, 32'h1234);
      #1;
      check_eq("x0.ready", 64'(bus_if.req_ready), 64'b001);
      step();
      check_rf("x0", 1'b0, 5'd9, 32'h99);
      bus_if.req_valid = 3'b111;
      #1;
      check_eq("x0.ptr", 64'(bus_if.req_ready), 64'b010);
      bus_if.req_valid = 3'b100;
      #1;
      check_eq("pre_hold.ready", 64'(bus_if.req_ready), 64'b100);
      step();

      hold             = 1'b1;
      bus_if.req_valid = 3'b101;
      set_req(0, 5'd4, 32'h44);
      #1;
      check_eq("hold.ready", 64'(bus_if.req_ready), 64'd0);
      check_eq("hold.contend", 64'(contend), 64'd0);
      check_rf("hold.prev", 1'b1, 5'd3, 32'hC2);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("hold.ready_n", 64'(bus_if.req_ready), 64'd0);
         check_eq("hold.contend_n", 64'(contend), 64'd0);
         check_eq("hold.rf_en", 64'(bus_if.rf_en), 64'd0);
      end
      hold = 1'b0;
      #1;
      check_eq("unhold.ready", 64'(bus_if.req_ready), 64'b001);
      step();
      check_rf("unhold", 1'b1, 5'd4, 32'h44);

      bus_if.req_valid = 3'b010;
      set_req(1, 5'd7, 32'h11);
      #1;
      check_eq("ord.ready0", 64'(bus_if.req_ready), 64'b010);
      step();
      check_rf("ord.w0", 1'b1, 5'd7, 32'h11);
      bus_if.req_valid = 3'b100;
      set_req(2, 5'd7, 32'h22);
      #1;
      check_eq("ord.ready1", 64'(bus_if.req_ready), 64'b100);
      step();
      check_rf("ord.w1", 1'b1, 5'd7, 32'h22);
      bus_if.req_valid = 3'b000;
      step();
      check_eq("ord.model_x7", 64'(rf_model[7]), 64'h22);

      bus_if.req_valid = 3'b001;
      set_req(0, 5'd10, 32'h55);
      #1;
      check_eq("mid.ready", 64'(bus_if.req_ready), 64'b001);
      step();
      check_rf("mid.pre", 1'b1, 5'd10, 32'h55);
      bus_if.req_valid = 3'b111;
      #2;
      rst_n = 1'b0;
      #1;
      check_rf("mid.rst", 1'b0, 5'd0, 32'd0);
      check_eq("mid.rst_ready", 64'(bus_if.req_ready), 64'd0);
      check_eq("mid.rst_contend", 64'(contend), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("mid.release_ready", 64'(bus_if.req_ready), 64'b001);
      step();
      check_rf("mid.first", 1'b1, 5'd10, 32'h55);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
